// File: rtl/tensor_core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tensor_core_pkg
// Description : Shared types and constants for the tensor core vocabulary
//               blocks (matcher / decoder).
// Revision    : 1.0  initial release
// ============================================================================
package tensor_core_pkg;

  // Decoder states carry a DEC_ prefix so they never collide with the
  // matcher's state names when both packages' symbols are imported together.
  typedef enum logic [2:0] {
    DEC_IDLE  = 3'd0,
    DEC_FETCH = 3'd1,
    DEC_CHECK = 3'd2,
    DEC_EMIT  = 3'd3,
    DEC_DONE  = 3'd4,
    DEC_ERR   = 3'd5
  } decoder_state;

  // Byte value that terminates every word in the vocabulary memory.
  localparam int VOCAB_TERM = 0;

endpackage
`default_nettype wire

// File: rtl/vocab_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : vocab_decoder_if
// Description : Vocab memory read port plus the outgoing character stream
//               (valid/ready) of the vocabulary decoder.
// Revision    : 1.0  initial release
// ============================================================================
interface vocab_decoder_if #(
  parameter int VOCAB_ADDR_WIDTH = 4,
  parameter int DATA_WIDTH       = 8
);

  // Vocab memory read port: data is mem[addr_v] one cycle later.
  logic [VOCAB_ADDR_WIDTH-1:0] addr_v;
  logic [DATA_WIDTH-1:0]       val_vocab;

  // Character output stream.
  logic [DATA_WIDTH-1:0]       out_data;
  logic                        out_valid;
  logic                        out_ready;

  // Decoder side.
  modport master (
    output addr_v,
    input  val_vocab,
    output out_data,
    output out_valid,
    input  out_ready
  );

  // Memory / downstream side.
  modport slave (
    input  addr_v,
    output val_vocab,
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface
`default_nettype wire

// File: rtl/vocab_decoder.sv
`default_nettype none
// ============================================================================
// Module      : vocab_decoder
// Description : Given a token index, walks the zero-terminated vocabulary
//               memory and streams that word's characters out over a
//               valid/ready interface.
// Revision    : 1.0  initial release
// ============================================================================
module vocab_decoder
  import tensor_core_pkg::*;
#(
  parameter int VOCAB_ADDR_WIDTH = 4,
  parameter int DATA_WIDTH       = 8,
  parameter int TOKEN_WIDTH      = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [TOKEN_WIDTH-1:0]      token_id,
  input  logic [VOCAB_ADDR_WIDTH-1:0] vocab_start_addr,
  input  logic [VOCAB_ADDR_WIDTH-1:0] vocab_end_addr,
  vocab_decoder_if.master             bus,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  decoder_state                state, state_d;
  logic [TOKEN_WIDTH-1:0]      cnt, cnt_d;           // terminators left to skip
  logic                        emitted, emitted_d;   // at least one char sent
  logic [VOCAB_ADDR_WIDTH-1:0] addr, addr_d;
  logic [DATA_WIDTH-1:0]       data, data_d;
  logic                        valid, valid_d;
  logic                        busy_d, done_d, err_d;
  logic                        is_term;

  assign is_term       = (bus.val_vocab == DATA_WIDTH'(VOCAB_TERM));
  assign bus.addr_v    = addr;
  assign bus.out_data  = data;
  assign bus.out_valid = valid;

  // State and datapath registers; async reset drops any pending character.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= DEC_IDLE;
      cnt     <= '0;
      emitted <= 1'b0;
      addr    <= '0;
      data    <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      emitted <= emitted_d;
      addr    <= addr_d;
      data    <= data_d;
      valid   <= valid_d;
      busy    <= busy_d;
      done    <= done_d;
      err     <= err_d;
    end
  end

  // Next-state and datapath updates; status flags are registered from the
  // next state so they line up exactly with the state they describe.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    emitted_d = emitted;
    addr_d    = addr;
    data_d    = data;
    valid_d   = valid;

    case (state)
      DEC_IDLE: begin
        // Keep the read address parked at the start of the vocabulary.
        addr_d = vocab_start_addr;
        if (start) begin
          cnt_d     = token_id;
          emitted_d = 1'b0;
          state_d   = DEC_FETCH;
        end
      end

      DEC_FETCH: begin
        // End check precedes every read, so a wrapped walk never reads
        // past the vocabulary end.
        if (addr == vocab_end_addr) begin
          state_d = DEC_ERR;
        end else begin
          state_d = DEC_CHECK;
        end
      end

      DEC_CHECK: begin
        if (cnt != '0) begin
          if (is_term) begin
            cnt_d = cnt - TOKEN_WIDTH'(1);
          end
          addr_d  = addr + VOCAB_ADDR_WIDTH'(1);
          state_d = DEC_FETCH;
        end else if (is_term) begin
          // A terminator before any character means an empty word.
          state_d = emitted ? DEC_DONE : DEC_ERR;
        end else begin
          data_d  = bus.val_vocab;
          valid_d = 1'b1;
          state_d = DEC_EMIT;
        end
      end

      DEC_EMIT: begin
        if (bus.out_ready) begin
          valid_d   = 1'b0;
          emitted_d = 1'b1;
          addr_d    = addr + VOCAB_ADDR_WIDTH'(1);
          state_d   = DEC_FETCH;
        end
      end

      DEC_DONE, DEC_ERR: begin
        // A new start restarts the walk from the vocabulary start.
        if (start) begin
          addr_d    = vocab_start_addr;
          cnt_d     = token_id;
          emitted_d = 1'b0;
          state_d   = DEC_FETCH;
        end
      end

      default: begin
        state_d = DEC_IDLE;
      end
    endcase

    busy_d = (state_d == DEC_FETCH) || (state_d == DEC_CHECK) ||
             (state_d == DEC_EMIT);
    done_d = (state_d == DEC_DONE);
    err_d  = (state_d == DEC_ERR);
  end

endmodule
`default_nettype wire

// File: tb/tb_vocab_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_vocab_decoder
// Description : Self-checking bench for vocab_decoder: a word-level model
//               predicts the character stream, the final status and the
//               latencies; a per-cycle monitor checks the stream.
// Revision    : 1.0  initial release
// ============================================================================
module tb_vocab_decoder;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [TW-1:0] token_id = '0;
  logic [AW-1:0] vstart = '0;
  logic [AW-1:0] vend = '0;
  logic          busy, done, err;

  logic [DW-1:0] mem [16];
  logic [DW-1:0] exp_q [$];

  int checks = 0;
  int errors = 0;
  bit no_cmp = 1'b1;

  vocab_decoder_if #(.VOCAB_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  vocab_decoder #(
    .VOCAB_ADDR_WIDTH(AW),
    .DATA_WIDTH      (DW),
    .TOKEN_WIDTH     (TW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .token_id        (token_id),
    .vocab_start_addr(vstart),
    .vocab_end_addr  (vend),
    .bus             (bus),
    .busy            (busy),
    .done            (done),
    .err             (err)
  );

  always #5 clk = ~clk;

  // One-cycle synchronous read memory.
  always @(posedge clk) bus.val_vocab <= mem[bus.addr_v];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word-level model: walk the vocabulary by the decoding rules and return
  // the characters, bytes skipped (s), characters emitted (k), final status
  // and how the walk ended (tail=2 on a terminator read, 1 on hitting end).
  task automatic model(input int tok, output int s, output int k,
                       output bit is_err, output int tail);
    int a;
    int c;
    a = int'(vstart);
    c = tok;
    s = 0;
    k = 0;
    is_err = 1'b1;
    tail = 1;
    exp_q.delete();
    for (int it = 0; it < 64; it++) begin
      if (a == int'(vend)) begin
        is_err = 1'b1;
        tail = 1;
        return;
      end
      if (c != 0) begin
        if (mem[a] == 0) c--;
        s++;
      end else if (mem[a] == 0) begin
        is_err = (k == 0);
        tail = 2;
        return;
      end else begin
        exp_q.push_back(mem[a]);
        k++;
      end
      a = (a + 1) % 16;
    end
  endtask

  // Stream monitor: handshaked characters against the model queue, and
  // valid/data/address stability while stalled.
  logic          pv = 1'b0;
  logic          pr = 1'b0;
  logic [DW-1:0] pd = '0;
  logic [AW-1:0] pa = '0;
  always @(negedge clk) begin
    if (!rst_n || no_cmp) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        check("valid_held", bus.out_valid, 1);
        check("data_stable", bus.out_data, pd);
        check("addr_frozen", bus.addr_v, pa);
      end
      check("done_err_exclusive", done && err, 0);
      if (bus.out_valid) check("valid_implies_busy", busy, 1);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("extra_char", exp_q.size(), 1);
        else check("char", bus.out_data, exp_q.pop_front());
      end
      pv = bus.out_valid;
      pr = bus.out_ready;
      pd = bus.out_data;
      pa = bus.addr_v;
    end
  end

  // One decode: rmode 0 = ready high, 1 = random ready, 2 = ready held low
  // for 4 cycles at the first character. pulse re-asserts start mid-walk.
  task automatic run(input int tok, input int rmode, input bit pulse,
                     output int first, output int nlat);
    int s, k, tail;
    bit is_err;
    model(tok, s, k, is_err, tail);
    @(posedge clk); #1;
    token_id = TW'(tok);
    start = 1'b1;
    bus.out_ready = (rmode == 0) ? 1'b1 : 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    nlat = 1;
    first = -1;
    check("start_clears_done", done, 0);
    check("start_clears_err", err, 0);
    check("busy_after_start", busy, 1);
    forever begin
      start = pulse && (nlat == 3);
      if (start) token_id = ~token_id;
      if (first < 0 && bus.out_valid) first = nlat;
      if (done || err || nlat >= 400) break;
      case (rmode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = (first >= 0) && (nlat >= first + 4);
      endcase
      @(posedge clk); #1;
      nlat++;
    end
    start = 1'b0;
    check("finished_in_time", done || err, 1);
    check("done_flag", done, !is_err);
    check("err_flag", err, is_err);
    check("all_chars_sent", exp_q.size(), 0);
    check("busy_at_end", busy, 0);
    if (rmode == 0) check("end_latency", nlat, 1 + 2 * s + 3 * k + tail);
    if (k > 0) check("first_valid_latency", first, 3 + 2 * s);
    else check("no_valid_seen", first, -1);
  endtask

  initial begin
    int f, l, s, k, tail, n;
    bit e;

    bus.out_ready = 1'b0;
    mem = '{8'h48, 8'h49, 8'h00, 8'h4F, 8'h4B, 8'h00, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vstart = 4'd0;
    vend = 4'd8;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_addr_v", bus.addr_v, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    no_cmp = 1'b0;

    // Pin the model on the reference vocabulary.
    model(1, s, k, e, tail);
    check("pin_tok1_len", exp_q.size(), 2);
    check("pin_tok1_c0", exp_q[0], 8'h4F);
    check("pin_tok1_c1", exp_q[1], 8'h4B);
    check("pin_tok1_skip", s, 3);
    exp_q.delete();

    // Directed cases on the reference vocabulary.
    run(1, 0, 1'b0, f, l);
    check("tok1_first_lit", f, 9);
    check("tok1_end_lit", l, 15);
    run(0, 2, 1'b0, f, l);
    check("tok0_first_lit", f, 3);
    run(2, 0, 1'b0, f, l);
    check("tok2_err_lit", err, 1);
    check("tok2_end_lit", l, 15);
    run(5, 0, 1'b0, f, l);
    check("tok5_err_lit", err, 1);
    check("tok5_end_lit", l, 18);
    run(1, 0, 1'b1, f, l);
    check("pulse_ignored_end", l, 15);

    // Reset while a character is pending.
    model(0, s, k, e, tail);
    @(posedge clk); #1;
    token_id = 4'd0;
    start = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("stall_valid", bus.out_valid, 1);
    repeat (3) @(posedge clk);
    #1;
    check("stall_data", bus.out_data, 8'h48);
    check("stall_addr", bus.addr_v, 0);
    no_cmp = 1'b1;
    rst_n = 1'b0;
    #1;
    check("emit_rst_valid", bus.out_valid, 0);
    check("emit_rst_addr", bus.addr_v, 0);
    check("emit_rst_busy", busy, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    no_cmp = 1'b0;
    run(0, 0, 1'b0, f, l);
    check("post_rst_tok0_end", l, 1 + 0 + 6 + 2);

    // Randomized vocabularies, bounds, tokens and back-pressure.
    for (int t = 0; t < 40; t++) begin
      foreach (mem[i]) mem[i] = ($urandom_range(0, 9) < 4) ? 8'h00 : DW'($urandom_range(1, 255));
      vstart = AW'($urandom_range(0, 15));
      vend = AW'($urandom_range(0, 15));
      run($urandom_range(0, 5), $urandom_range(0, 1), ($urandom_range(0, 3) == 0), f, l);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
